// File: rtl/audio_pkg.sv
// Shared types and helpers for the audio sample sequencer: state encoding and
// a saturating signed add for the default sample width.
package audio_pkg;

  localparam int unsigned DefaultSampleW = 24;

  typedef enum logic [1:0] {IDLE, READ, MIX, WRITE} seq_state_t;

  typedef struct packed {
    logic [DefaultSampleW-1:0] value;
    logic                      sat;
  } sat_res_t;

  // Signed add at one extra bit, clamped back to the sample range.
  function automatic sat_res_t sat_add(input logic [DefaultSampleW-1:0] a,
                                       input logic [DefaultSampleW-1:0] b);
    logic [DefaultSampleW:0] wide;
    sat_res_t                res;
    wide    = {a[DefaultSampleW-1], a} + {b[DefaultSampleW-1], b};
    res.sat = wide[DefaultSampleW] ^ wide[DefaultSampleW-1];
    if (!res.sat) begin
      res.value = wide[DefaultSampleW-1:0];
    end else if (wide[DefaultSampleW]) begin
      res.value = {1'b1, {(DefaultSampleW-1){1'b0}}};
    end else begin
      res.value = {1'b0, {(DefaultSampleW-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Combinational saturating signed adder, one instance per audio channel.
module sat_adder #(
  parameter int unsigned SAMPLE_W = 24
) (
  input  logic [SAMPLE_W-1:0] a_i,
  input  logic [SAMPLE_W-1:0] b_i,
  output logic [SAMPLE_W-1:0] sum_o,
  output logic                sat_o
);

  logic [SAMPLE_W:0] wide;

  always_comb begin
    wide  = {a_i[SAMPLE_W-1], a_i} + {b_i[SAMPLE_W-1], b_i};
    // The two top bits disagree exactly when the true sum left the range.
    sat_o = wide[SAMPLE_W] ^ wide[SAMPLE_W-1];
    if (!sat_o) begin
      sum_o = wide[SAMPLE_W-1:0];
    end else if (wide[SAMPLE_W]) begin
      sum_o = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      sum_o = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/audio_sample_sequencer.sv
// CODEC sample handshake: wait for ready pair, read, mix noise (saturating),
// write, and keep sample / saturation statistics.
module audio_sample_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DefaultSampleW,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                read_ready,
  input  logic                write_ready,
  input  logic [SAMPLE_W-1:0] readdata_left,
  input  logic [SAMPLE_W-1:0] readdata_right,
  input  logic [SAMPLE_W-1:0] noise_in,
  input  logic                noise_on,
  output logic                read,
  output logic                write,
  output logic [SAMPLE_W-1:0] writedata_left,
  output logic [SAMPLE_W-1:0] writedata_right,
  output logic                noise_step,
  output logic                busy,
  output logic [CNT_W-1:0]    sample_count,
  output logic [CNT_W-1:0]    sat_count
);

  seq_state_t          state_q;
  logic [SAMPLE_W-1:0] smp_l_q, smp_r_q, noise_q;
  logic [SAMPLE_W-1:0] wd_l_q, wd_r_q;
  logic [CNT_W-1:0]    smp_cnt_q, sat_cnt_q, sat_cnt_d;
  logic [SAMPLE_W-1:0] mix_l, mix_r;
  logic                sat_l, sat_r;
  logic [1:0]          sat_inc;
  logic [CNT_W:0]      sat_sum;

  sat_adder #(.SAMPLE_W(SAMPLE_W)) u_sat_l (
    .a_i  (smp_l_q),
    .b_i  (noise_q),
    .sum_o(mix_l),
    .sat_o(sat_l)
  );

  sat_adder #(.SAMPLE_W(SAMPLE_W)) u_sat_r (
    .a_i  (smp_r_q),
    .b_i  (noise_q),
    .sum_o(mix_r),
    .sat_o(sat_r)
  );

  // Clamp flags only count when the noise is actually mixed in.
  always_comb begin
    sat_inc   = noise_on ? ({1'b0, sat_l} + {1'b0, sat_r}) : 2'd0;
    sat_sum   = {1'b0, sat_cnt_q} + {{(CNT_W-1){1'b0}}, sat_inc};
    sat_cnt_d = sat_sum[CNT_W] ? {CNT_W{1'b1}} : sat_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      smp_l_q   <= '0;
      smp_r_q   <= '0;
      noise_q   <= '0;
      wd_l_q    <= '0;
      wd_r_q    <= '0;
      smp_cnt_q <= '0;
      sat_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (read_ready && write_ready) state_q <= READ;
        READ: begin
          smp_l_q <= readdata_left;
          smp_r_q <= readdata_right;
          noise_q <= noise_in;
          state_q <= MIX;
        end
        MIX: begin
          wd_l_q    <= noise_on ? mix_l : smp_l_q;
          wd_r_q    <= noise_on ? mix_r : smp_r_q;
          sat_cnt_q <= sat_cnt_d;
          state_q   <= WRITE;
        end
        WRITE: begin
          if (write_ready) begin
            smp_cnt_q <= smp_cnt_q + 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read            = (state_q == READ);
  assign noise_step      = (state_q == MIX);
  assign write           = (state_q == WRITE) && write_ready;
  assign busy            = (state_q != IDLE);
  assign writedata_left  = wd_l_q;
  assign writedata_right = wd_r_q;
  assign sample_count    = smp_cnt_q;
  assign sat_count       = sat_cnt_q;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Scoreboard bench for audio_sample_sequencer; a narrow-counter twin instance
// exercises counter wrap and saturation within a short run.
module tb_audio_sample_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        read_ready, write_ready, noise_on;
  logic [23:0] rd_l, rd_r, noise;

  logic        read, write, noise_step, busy;
  logic [23:0] wd_l, wd_r;
  logic [15:0] sample_count, sat_count;

  logic        sm_read, sm_write, sm_noise_step, sm_busy;
  logic [23:0] sm_wd_l, sm_wd_r;
  logic [2:0]  sm_sample_count, sm_sat_count;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0, exp_sat = 0, exp_sm_cnt = 0, exp_sm_sat = 0;

  always #5 clk = ~clk;

  audio_sample_sequencer #(.SAMPLE_W(24), .CNT_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .read_ready     (read_ready),
    .write_ready    (write_ready),
    .readdata_left  (rd_l),
    .readdata_right (rd_r),
    .noise_in       (noise),
    .noise_on       (noise_on),
    .read           (read),
    .write          (write),
    .writedata_left (wd_l),
    .writedata_right(wd_r),
    .noise_step     (noise_step),
    .busy           (busy),
    .sample_count   (sample_count),
    .sat_count      (sat_count)
  );

  audio_sample_sequencer #(.SAMPLE_W(24), .CNT_W(3)) dut_sm (
    .clk            (clk),
    .reset_n        (reset_n),
    .read_ready     (read_ready),
    .write_ready    (write_ready),
    .readdata_left  (rd_l),
    .readdata_right (rd_r),
    .noise_in       (noise),
    .noise_on       (noise_on),
    .read           (sm_read),
    .write          (sm_write),
    .writedata_left (sm_wd_l),
    .writedata_right(sm_wd_r),
    .noise_step     (sm_noise_step),
    .busy           (sm_busy),
    .sample_count   (sm_sample_count),
    .sat_count      (sm_sat_count)
  );

  task automatic model(input logic [23:0] a, input logic [23:0] n, input logic on,
                       output logic [23:0] y, output int s);
    longint v;
    v = longint'($signed(a)) + longint'($signed(n));
    s = 0;
    if (!on) begin
      y = a;
    end else if (v > 64'sd8388607) begin
      y = 24'h7FFFFF;
      s = 1;
    end else if (v < -64'sd8388608) begin
      y = 24'h800000;
      s = 1;
    end else begin
      y = v[23:0];
    end
  endtask

  // Called at a negedge while the DUT is IDLE; returns at the IDLE negedge after the write.
  task automatic run_sample(input logic [23:0] l, input logic [23:0] r, input logic [23:0] n,
                            input logic on, input int stall);
    exp_t e, got;
    int   sl, sr;
    model(l, n, on, e.l, sl);
    model(r, n, on, e.r, sr);
    sb.push_back(e);
    exp_sat    = (exp_sat + sl + sr > 65535) ? 65535 : exp_sat + sl + sr;
    exp_sm_sat = (exp_sm_sat + sl + sr > 7) ? 7 : exp_sm_sat + sl + sr;
    rd_l = l; rd_r = r; noise = n; noise_on = on;
    read_ready = 1'b1; write_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({read, busy, noise_step, write} !== 4'b1100) begin
      n_err++;
      $display("FAIL read_phase: got %b required 1100", {read, busy, noise_step, write});
    end
    read_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({read, busy, noise_step, write} !== 4'b0110) begin
      n_err++;
      $display("FAIL mix_phase: got %b required 0110", {read, busy, noise_step, write});
    end
    rd_l = ~l; rd_r = ~r; noise = $urandom;
    if (stall > 0) write_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      n_vec++;
      if (write !== 1'b0 || busy !== 1'b1 || wd_l !== e.l || wd_r !== e.r) begin
        n_err++;
        $display("FAIL stall_hold: write=%b busy=%b wd=%h/%h required 0 1 %h/%h",
                 write, busy, wd_l, wd_r, e.l, e.r);
      end
      @(negedge clk);
    end
    write_ready = 1'b1;
    #1;
    n_vec++;
    if (write !== 1'b1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL write_strobe: write=%b busy=%b required 1 1", write, busy);
    end
    got = sb.pop_front();
    n_vec++;
    if (wd_l !== got.l || wd_r !== got.r) begin
      n_err++;
      $display("FAIL writedata: got %h/%h required %h/%h", wd_l, wd_r, got.l, got.r);
    end
    exp_cnt    = (exp_cnt + 1) % 65536;
    exp_sm_cnt = (exp_sm_cnt + 1) % 8;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || write !== 1'b0 || read !== 1'b0) begin
      n_err++;
      $display("FAIL back_to_idle: busy=%b write=%b read=%b required 000", busy, write, read);
    end
    n_vec++;
    if (sample_count !== 16'(exp_cnt) || sat_count !== 16'(exp_sat)) begin
      n_err++;
      $display("FAIL counters: got %h/%h required %h/%h", sample_count, sat_count,
               16'(exp_cnt), 16'(exp_sat));
    end
    n_vec++;
    if (sm_sample_count !== 3'(exp_sm_cnt) || sm_sat_count !== 3'(exp_sm_sat)) begin
      n_err++;
      $display("FAIL narrow_counters: got %0d/%0d required %0d/%0d", sm_sample_count,
               sm_sat_count, exp_sm_cnt, exp_sm_sat);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; read_ready = 1'b0; write_ready = 1'b0; noise_on = 1'b0;
    rd_l = '0; rd_r = '0; noise = '0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({read, write, noise_step, busy} !== 4'b0000 || wd_l !== 24'h0 || wd_r !== 24'h0 ||
        sample_count !== 16'h0 || sat_count !== 16'h0) begin
      n_err++;
      $display("FAIL reset_state: strobes=%b wd=%h/%h cnt=%h/%h required zeros",
               {read, write, noise_step, busy}, wd_l, wd_r, sample_count, sat_count);
    end
    reset_n = 1'b1;
    write_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || read !== 1'b0) begin
      n_err++;
      $display("FAIL idle_wait: busy=%b read=%b required 0 0", busy, read);
    end
  endtask

  task automatic test_basic();
    run_sample(24'h000100, 24'hFFFF00, 24'h000800, 1'b1, 0);
    n_vec++;
    if (wd_l !== 24'h000900 || wd_r !== 24'h000700 || sample_count !== 16'd1 ||
        sat_count !== 16'd0) begin
      n_err++;
      $display("FAIL basic_literal: got %h/%h cnt %0d sat %0d required 000900/000700 1 0",
               wd_l, wd_r, sample_count, sat_count);
    end
  endtask

  task automatic test_saturation();
    run_sample(24'h7FFFF0, 24'h800005, 24'h000800, 1'b1, 0);
    n_vec++;
    if (wd_l !== 24'h7FFFFF) begin
      n_err++;
      $display("FAIL clamp_high: got %h required 7fffff", wd_l);
    end
    run_sample(24'h7FFFF0, 24'h800005, 24'hFFF800, 1'b1, 0);
    n_vec++;
    if (wd_r !== 24'h800000 || sat_count !== 16'd2) begin
      n_err++;
      $display("FAIL clamp_low: got %h sat %0d required 800000 2", wd_r, sat_count);
    end
  endtask

  task automatic test_bypass();
    run_sample(24'h123456, 24'h7FFFF0, 24'h7FFFFF, 1'b0, 0);
    n_vec++;
    if (wd_l !== 24'h123456 || sat_count !== 16'd2) begin
      n_err++;
      $display("FAIL bypass: got %h sat %0d required 123456 2", wd_l, sat_count);
    end
  endtask

  task automatic test_write_stall();
    run_sample(24'h0A0B0C, 24'hF0F0F0, 24'h001000, 1'b1, 10);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      run_sample(24'($urandom), 24'($urandom), 24'($urandom), 1'($urandom), 0);
    end
    read_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    rd_l = 24'h111111; rd_r = 24'h222222; noise = 24'h000100; noise_on = 1'b1;
    read_ready = 1'b1; write_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (noise_step !== 1'b1) begin
      n_err++;
      $display("FAIL reach_mix: noise_step=%b required 1", noise_step);
    end
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({read, write, noise_step, busy} !== 4'b0000 || wd_l !== 24'h0 || wd_r !== 24'h0 ||
        sample_count !== 16'h0 || sat_count !== 16'h0 || sm_sample_count !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: strobes=%b wd=%h/%h cnt=%h/%h required zeros",
               {read, write, noise_step, busy}, wd_l, wd_r, sample_count, sat_count);
    end
    exp_cnt = 0; exp_sat = 0; exp_sm_cnt = 0; exp_sm_sat = 0;
    read_ready = 1'b1; write_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || read !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: busy=%b read=%b required 0 0", busy, read);
    end
  endtask

  task automatic test_counter_limits();
    for (int i = 0; i < 9; i++) begin
      run_sample(24'h7FFFF0, 24'h7FFFF0, 24'h000800, 1'b1, 0);
    end
    read_ready = 1'b0;
    n_vec++;
    if (sm_sample_count !== 3'd1 || sm_sat_count !== 3'd7 || sat_count !== 16'd18) begin
      n_err++;
      $display("FAIL counter_limits: got cnt %0d sat %0d wide sat %0d required 1 7 18",
               sm_sample_count, sm_sat_count, sat_count);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_bypass();
    test_write_stall();
    test_back_to_back();
    test_reset_mid();
    test_counter_limits();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
